// File: rtl/apb_memif_pkg.sv
// Shared types, default parameters and width helpers for the APB multi-channel
// memory bridge.
package apb_memif_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_CH_AW      = 12;
    localparam int DEF_TIMEOUT    = 16;

    // Channel index width, kept at least one bit so a single-channel build still has a vector.
    function automatic int idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int timer_w(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_memif_xbar_if.sv
// APB slave port plus the shared/per-channel memory-side signals of the bridge.
interface apb_memif_xbar_if
    import apb_memif_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH
);

    logic                                  psel_i;
    logic                                  penable_i;
    logic                                  pwrite_i;
    logic [ADDR_WIDTH-1:0]                 paddr_i;
    logic [DATA_WIDTH-1:0]                 pwdata_i;
    logic [DATA_WIDTH/8-1:0]               pstrb_i;
    logic                                  pready_o;
    logic                                  pslverr_o;
    logic [DATA_WIDTH-1:0]                 prdata_o;

    logic [NUM_CH-1:0]                     mreq_o;
    logic [ADDR_WIDTH-1:0]                 maddr_o;
    logic                                  mwe_o;
    logic [DATA_WIDTH-1:0]                 mwdata_o;
    logic [DATA_WIDTH/8-1:0]               mstrb_o;
    logic [NUM_CH-1:0]                     mack_i;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]     mrdata_i;
    logic [NUM_CH-1:0]                     mresp_i;

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
        output pready_o, pslverr_o, prdata_o,
        output mreq_o, maddr_o, mwe_o, mwdata_o, mstrb_o,
        input  mack_i, mrdata_i, mresp_i
    );

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
        input  pready_o, pslverr_o, prdata_o,
        input  mreq_o, maddr_o, mwe_o, mwdata_o, mstrb_o,
        output mack_i, mrdata_i, mresp_i
    );

endinterface

// File: rtl/apb_memif_decode.sv
// Address decoder: splits an APB address into channel index, in-window offset
// and a hit flag for the mapped channel windows.
module apb_memif_decode
    import apb_memif_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int CH_AW      = DEF_CH_AW
) (
    input  logic [ADDR_WIDTH-1:0]      paddr,
    output logic                       hit,
    output logic [idx_w(NUM_CH)-1:0]   ch,
    output logic [ADDR_WIDTH-1:0]      laddr
);

    localparam int IW = idx_w(NUM_CH);
    localparam int FW = $clog2(NUM_CH);

    always_comb begin
        // With one channel there is no index field; every bit above the window must be zero.
        ch    = (FW == 0) ? '0 : paddr[CH_AW +: IW];
        hit   = ((paddr >> (CH_AW + FW)) == '0) &&
                ({{(32-IW){1'b0}}, ch} < 32'(NUM_CH));
        laddr = ADDR_WIDTH'(paddr[CH_AW-1:0]);
    end

endmodule

// File: rtl/apb_memif_xbar.sv
// APB slave bridging single accesses onto NUM_CH request/acknowledge memory
// channels, with decode-miss and timeout error responses.
module apb_memif_xbar
    import apb_memif_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int CH_AW      = DEF_CH_AW,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    apb_memif_xbar_if.slave  bus
);

    localparam int IW = idx_w(NUM_CH);
    localparam int TW = timer_w(TIMEOUT);

    state_e                state, state_nxt;
    logic [IW-1:0]         ch_q, dec_ch, sel_ch;
    logic                  dec_hit;
    logic [ADDR_WIDTH-1:0] dec_addr;
    logic [TW-1:0]         timer_q;
    logic [DATA_WIDTH-1:0] prdata_q, cap_data;
    logic                  pslverr_q, cap_err, cap_en, tmr_clr;
    logic                  access, ack, expired;
    logic [NUM_CH-1:0]     mreq;

    apb_memif_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_CH     (NUM_CH),
        .CH_AW      (CH_AW)
    ) u_decode (
        .paddr (bus.paddr_i),
        .hit   (dec_hit),
        .ch    (dec_ch),
        .laddr (dec_addr)
    );

    // Reset gates the access so no request pulse leaks out while the bridge is held in reset.
    assign access  = bus.psel_i & bus.penable_i & arst_ni;
    assign sel_ch  = (state == IDLE) ? dec_ch : ch_q;
    assign ack     = bus.mack_i[sel_ch];
    assign expired = (TIMEOUT > 0) && (timer_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (access) state_nxt = (dec_hit && !ack) ? WAIT : DONE;
            WAIT:    if (ack || expired) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mreq     = '0;
        cap_en   = 1'b0;
        cap_err  = 1'b0;
        cap_data = '0;
        tmr_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    tmr_clr = 1'b1;
                    if (dec_hit) begin
                        mreq[dec_ch] = 1'b1;
                        if (ack) begin
                            cap_en   = 1'b1;
                            cap_err  = bus.mresp_i[sel_ch];
                            cap_data = bus.mrdata_i[sel_ch];
                        end
                    end else begin
                        cap_en  = 1'b1;
                        cap_err = 1'b1;
                    end
                end
            end
            WAIT: begin
                // An acknowledge arriving in the expiry cycle takes priority over the timeout.
                if (ack) begin
                    cap_en   = 1'b1;
                    cap_err  = bus.mresp_i[sel_ch];
                    cap_data = bus.mrdata_i[sel_ch];
                end else if (expired) begin
                    cap_en  = 1'b1;
                    cap_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ch_q      <= '0;
            timer_q   <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            if (state == IDLE && access && dec_hit) ch_q <= dec_ch;
            if (tmr_clr)                                timer_q <= '0;
            else if (state == WAIT && timer_q != '1)    timer_q <= timer_q + 1'b1;
            if (cap_en) begin
                prdata_q  <= cap_data;
                pslverr_q <= cap_err;
            end
        end
    end

    assign bus.pready_o  = (state == DONE);
    assign bus.pslverr_o = pslverr_q;
    assign bus.prdata_o  = prdata_q;
    assign bus.mreq_o    = mreq;
    assign bus.maddr_o   = dec_addr;
    assign bus.mwe_o     = bus.pwrite_i;
    assign bus.mwdata_o  = bus.pwdata_i;
    assign bus.mstrb_o   = bus.pstrb_i;

endmodule

// File: tb/tb_apb_memif_xbar.sv
// Randomized bench for apb_memif_xbar: directed scenarios then random
// transfers checked against a transaction-level response model.
module tb_apb_memif_xbar;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NCH = 4;
    localparam int CHAW = 12;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    apb_memif_xbar_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

    apb_memif_xbar #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .CH_AW      (CHAW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_i   (clk),
        .arst_ni (arst_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction-level model: latency from request cycle to pready, and the response.
    function automatic void model(input logic [31:0] addr, input int k, input logic [31:0] rd,
                                  input bit rsp, output int lat, output logic [31:0] d,
                                  output bit e);
        bit hit;
        hit = addr < (NCH << CHAW);
        if (!hit) begin
            lat = 1; d = '0; e = 1'b1;
        end else if (k >= 0 && k <= TMO) begin
            lat = k + 1; d = rd; e = rsp;
        end else begin
            lat = TMO + 1; d = '0; e = 1'b1;
        end
    endfunction

    task automatic xfer(input logic [31:0] addr, input bit we, input logic [31:0] wd,
                        input logic [3:0] strb, input int k, input logic [31:0] rd,
                        input bit rsp, input bit wrong);
        int ch, oth, got, lat;
        logic [31:0] exp_d, got_d;
        bit exp_e, got_e, hit, extra_req;
        hit = addr < (NCH << CHAW);
        ch = int'((addr >> CHAW) & 3);
        oth = (ch + 1) % NCH;
        model(addr, k, rd, rsp, lat, exp_d, exp_e);
        got = -1; got_d = '0; got_e = 1'b0; extra_req = 1'b0;
        @(posedge clk); #1;
        bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = we;
        bus.paddr_i = addr; bus.pwdata_i = wd; bus.pstrb_i = strb;
        for (int i = 0; i < NCH; i++) begin
            bus.mrdata_i[i] = $urandom;
            bus.mresp_i[i] = 1'($urandom);
        end
        if (hit) begin
            bus.mrdata_i[ch] = rd;
            bus.mresp_i[ch] = rsp;
        end
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
        for (int c = 0; c <= 40; c++) begin
            bus.mack_i = '0;
            if (hit && c == k) bus.mack_i[ch] = 1'b1;
            if (wrong && c != k) bus.mack_i[oth] = 1'b1;
            @(negedge clk);
            if (c == 0) begin
                chk("mreq", bus.mreq_o, hit ? (64'd1 << ch) : 64'd0);
                chk("maddr", bus.maddr_o, addr & 32'hFFF);
                chk("mwe", bus.mwe_o, we);
                chk("mwdata_strb", {bus.mwdata_o, bus.mstrb_o}, {wd, strb});
            end else if (bus.mreq_o != '0) begin
                extra_req = 1'b1;
            end
            if (bus.pready_o) begin
                got = c; got_d = bus.prdata_o; got_e = bus.pslverr_o;
                break;
            end
            @(posedge clk); #1;
        end
        chk("latency", 64'(got), 64'(lat));
        chk("pslverr", got_e, exp_e);
        if (!we) chk("prdata", got_d, exp_d);
        chk("mreq_repeat", extra_req, 1'b0);
        @(posedge clk); #1;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.mack_i = '0;
        @(negedge clk);
        chk("pready_pulse", bus.pready_o, 1'b0);
    endtask

    // Acks on an idle bus, such as late acks after a timeout, must produce nothing.
    task automatic stray_acks(input int n);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            bus.mack_i = NCH'($urandom) | NCH'(1);
            @(negedge clk);
            if (bus.pready_o || bus.mreq_o != '0) seen = 1'b1;
        end
        @(posedge clk); #1;
        bus.mack_i = '0;
        chk("stray_ack", seen, 1'b0);
    endtask

    initial begin
        int dly [9] = '{0, 1, 2, 3, 5, 9, 16, 17, -1};
        logic [31:0] a;
        int k;
        bit miss_seen;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
        bus.paddr_i = '0; bus.pwdata_i = '0; bus.pstrb_i = '0;
        bus.mack_i = '0; bus.mrdata_i = '0; bus.mresp_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pready", bus.pready_o, 1'b0);
        chk("rst_pslverr", bus.pslverr_o, 1'b0);
        chk("rst_prdata", bus.prdata_o, 32'h0);
        chk("rst_mreq", bus.mreq_o, 4'h0);
        arst_n = 1'b1;

        xfer(32'h2010, 1'b0, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b0, 1'b0);
        xfer(32'h1044, 1'b1, 32'h12345678, 4'b0110, 3, 32'h0BADBEEF, 1'b1, 1'b0);
        xfer(32'h10000, 1'b0, 32'h0, 4'h0, -1, 32'h55AA55AA, 1'b0, 1'b0);
        xfer(32'h3100, 1'b0, 32'h0, 4'h0, -1, 32'hDEAD0001, 1'b0, 1'b0);
        stray_acks(4);
        xfer(32'h3200, 1'b0, 32'h0, 4'h0, 5, 32'h600DD00D, 1'b0, 1'b1);
        xfer(32'h0FFC, 1'b0, 32'h0, 4'h0, 16, 32'hA5A5A5A5, 1'b0, 1'b0);
        xfer(32'h0FFC, 1'b0, 32'h0, 4'h0, 17, 32'h5A5A5A5A, 1'b0, 1'b0);

        // Leave non-zero response registers behind, then reset in the middle of a wait.
        xfer(32'h1008, 1'b0, 32'h0, 4'h0, 1, 32'h13572468, 1'b1, 1'b0);
        @(posedge clk); #1;
        bus.psel_i = 1'b1; bus.paddr_i = 32'h1000; bus.pwrite_i = 1'b0;
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        arst_n = 1'b0;
        bus.mack_i = 4'b0010;
        #1;
        chk("arst_outs", {bus.pready_o, bus.pslverr_o, bus.prdata_o, bus.mreq_o},
            {1'b0, 1'b0, 32'h0, 4'h0});
        @(posedge clk); #1;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0;
        @(posedge clk); #1;
        arst_n = 1'b1;
        stray_acks(3);
        xfer(32'h1008, 1'b0, 32'h0, 4'h0, 2, 32'h0F0F1234, 1'b0, 1'b0);

        miss_seen = 1'b0;
        for (int t = 0; t < 60; t++) begin
            a = {20'h0, 2'($urandom), 8'($urandom), 2'b00};
            if ($urandom_range(0, 5) == 0) begin
                a = a | (32'h1 << $urandom_range(14, 31));
                miss_seen = 1'b1;
            end
            k = dly[$urandom_range(0, 8)];
            xfer(a, 1'($urandom), $urandom, 4'($urandom), k, $urandom, 1'($urandom),
                 ($urandom_range(0, 3) == 0));
        end
        if (!miss_seen) xfer(32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, 32'h1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_memif_xbar.md
# apb_memif_xbar

APB slave to multi-channel memory-interface bridge. It is the parametrised successor of the single-channel APB memory adapter. It decodes each APB access to one of `NUM_CH` memory channels, issues a single-cycle request, and waits for the channel acknowledge. It returns `pslverr` on unmapped addresses or when an access times out. It sits between the APB fabric and the peripheral register/memory banks (UART regs, FIFOs, scratch RAM).

## Interface
- `ADDR_WIDTH`, 32: APB and memory address width.
- `DATA_WIDTH`, 32: data width; strobe width is `DATA_WIDTH/8`.
- `NUM_CH`, 4: number of memory channels, ≥1.
- `CH_AW`, 12: per-channel window size is 2^`CH_AW` bytes.
- `TIMEOUT`, 16: maximum wait cycles after the request; 0 disables the timeout.

Ports:
- `clk_i` in 1: clock.
- `arst_ni` in 1: reset, asynchronous, active-low.
- `psel_i`, `penable_i`, `pwrite_i` in 1 each: APB control.
- `paddr_i` in `ADDR_WIDTH`: APB address.
- `pwdata_i` in `DATA_WIDTH`: APB write data.
- `pstrb_i` in `DATA_WIDTH/8`: APB byte strobe.
- `pready_o`, `pslverr_o` out 1 each: APB response, registered.
- `prdata_o` out `DATA_WIDTH`: read data, registered.
- `mreq_o` out `NUM_CH`: one-hot request pulse.
- `maddr_o` out `ADDR_WIDTH`: low `CH_AW` bits of `paddr_i`, upper bits zero; shared by all channels.
- `mwe_o` out 1, `mwdata_o` out `DATA_WIDTH`, `mstrb_o` out `DATA_WIDTH/8`: shared, combinational from APB.
- `mack_i` in `NUM_CH`: per-channel acknowledge.
- `mrdata_i` in `NUM_CH`×`DATA_WIDTH`: per-channel read data.
- `mresp_i` in `NUM_CH`: per-channel error flag.

## Operation
- Channel index: `paddr_i[CH_AW +: $clog2(NUM_CH)]`.
  - Hit: all bits above that index field are zero and index < `NUM_CH`.
  - Otherwise: decode miss.
- FSM has three states: IDLE, WAIT, DONE.
- **IDLE**, on `psel_i & penable_i`:
  - Hit: `mreq_o[ch]` is 1 in this cycle only (combinational). The index is latched into `ch_q` and the timer is cleared.
    - If `mack_i[ch]` is high in the same cycle, capture the response and go to DONE.
    - Otherwise go to WAIT.
  - Miss: no request is issued. Capture `pslverr=1`, `prdata=0`, go to DONE.
- **WAIT**: the timer increments every cycle.
  - `mack_i[ch_q]`: capture `mrdata_i[ch_q]` and `mresp_i[ch_q]`, go to DONE.
  - Otherwise, timer == `TIMEOUT-1` (with `TIMEOUT>0`): capture `pslverr=1`, `prdata=0`, go to DONE.
  - An ack in the same cycle as expiry wins; the data returns with no error.
- **DONE**: `pready_o`, `prdata_o` and `pslverr_o` are valid for exactly one cycle, then the FSM returns to IDLE.
- `pready_o` is 0 in every state except the DONE cycle. `prdata_o` and `pslverr_o` hold their last captured values.
- Ignored inputs:
  - `mack_i` on any non-selected channel, and any `mack_i` in IDLE or DONE (late acks after a timeout included).
  - `psel_i` or `penable_i` changes while in WAIT or DONE.
- Write accesses: `prdata_o` captures `mrdata_i[ch_q]` unchanged; the value is don't-care for the master.
- Timer width: `$clog2(TIMEOUT+1)`, minimum 1. It saturates and never wraps.

## Timing
- Reset: state IDLE, timer 0, `ch_q` 0. `pready_o`, `pslverr_o` and `prdata_o` are 0, and `mreq_o` is 0.
- Zero-wait ack (ack in the request cycle): `pready_o` is high in the next cycle. An APB access takes setup + 2 access cycles.
- Ack k cycles after the request: `pready_o` is high at request cycle + k + 1.
- Timeout: `pready_o` is high at request cycle + `TIMEOUT` + 1, with `pslverr_o=1`.
- Decode miss: `pready_o` is high in the next cycle, with `pslverr_o=1`.
- `mreq_o` is never asserted on two consecutive cycles and is never multi-hot.
- Reset mid-operation: all outputs drop immediately (asynchronous). A pending ack after reset is ignored.

## Structure
- Package `apb_memif_pkg`:
  - `state_e` enum (IDLE, WAIT, DONE).
  - Default parameter constants.
  - A `ch_idx_t`-style width helper.
- Sub-module `apb_memif_decode`: combinational; takes `paddr_i` and produces the hit flag, the channel index and the local address.
- Top level holds the FSM, timer, response capture and output muxing.

## Test plan
- Read, ch 2 (`paddr=0x2010`), `mack` same cycle, `mrdata=0xCAFEF00D` → `mreq_o=4'b0100` for one cycle, `maddr_o=0x010`; next cycle `pready_o=1`, `prdata_o=0xCAFEF00D`, `pslverr_o=0`.
- Write, ch 1, `mack` after 3 cycles with `mresp=1` → `mwe_o=1`, `mstrb_o` = `pstrb`; `pready_o` at request+4 with `pslverr_o=1`.
- Unmapped address `0x10000` → no `mreq_o`; next cycle `pready_o=1`, `pslverr_o=1`, `prdata_o=0`.
- No ack, `TIMEOUT=16` → `pready_o` at request+17 with `pslverr_o=1`. A late ack at +20 causes no `pready_o`, and the next transfer completes normally.
- Ack on the wrong channel (ch 0 while ch 3 is selected) → ignored; the transfer still waits, and `mack_i[3]` at +5 completes it.
- `arst_ni` low during WAIT → all outputs 0 at once; after release, a fresh read completes with the correct data.
